plab4_net_router_input_ctrl_domain_arb: RTL and testbench
=========================================================

// Module: plab4_net_router_input_ctrl_domain_arb
// PURPOSE
//  Input-port controller for a router shared by p_num_domains security domains. Each domain
//  has its own input queue head (val/dest). One route-compute instance per domain; a domain
//  arbiter picks one domain per cycle and forwards its reqs to the switch allocator.
//  Modes: fixed priority, round-robin with request lock, or time-division (TDM) slots that
//  close the cross-domain timing channel.
// PARAMETERS
//  p_router_id     0       id of this router
//  p_num_routers   8       routers in ring; sets dest width
//  p_num_domains   2       domains sharing this input port (>=2)
//  p_default_reqs  3'b001  reqs pattern when dest == p_router_id (terminal port)
//  p_mode          0       0=FIXED, 1=RR, 2=TDM
//  p_slot_cycles   4       TDM slot length in cycles (>=1); ignored unless p_mode==2
//  c_dest_nbits    $clog2(p_num_routers)        derived
//  c_dom_nbits     max(1,$clog2(p_num_domains)) derived
// PORTS
//  clk      in   1                            clock
//  reset    in   1                            synchronous, active-high reset
//  dest     in   p_num_domains*c_dest_nbits   flattened per-domain head dest; domain d at [d*W +: W]
//  in_val   in   p_num_domains                per-domain head valid
//  in_rdy   out  p_num_domains                per-domain dequeue strobe (head transfers this cycle)
//  reqs     out  3                            output-port request of selected domain
//  grants   in   3                            one-hot grant from switch allocator (same cycle)
//  cur_dom  out  c_dom_nbits                  domain currently selected (debug/monitor)
// BEHAVIOUR
//  - Per domain d: reqs_d = route(dest_d) & in_val[d]; zero when in_val[d]==0.
//  - sel = chosen domain; reqs = reqs_sel; grants forwarded only to sel; all other domains see
//    grants=0 -> in_rdy=0. in_rdy[sel] = in_val[sel] & |(grants & reqs_sel). reqs/in_rdy are
//    combinational from state + inputs; no added latency (grant and transfer same cycle).
//  - Transfer event xfer = |in_rdy. At most one in_rdy bit high per cycle.
//  - FIXED: sel = lowest d with reqs_d!=0; if none, sel=0 and reqs=0.
//  - RR: search starts at (ptr+1) mod N, wrapping; ptr <= sel on xfer only.
//  - Lock (FIXED, RR): if reqs_sel!=0 and no xfer, lock_vld<=1, lock_dom<=sel; while lock_vld,
//    sel=lock_dom. Lock clears on xfer by lock_dom or when in_val[lock_dom]==0. A new lock can
//    be set in the same cycle a stale one clears.
//  - TDM: owner counter cycles 0..N-1; slot_cnt counts 0..p_slot_cycles-1, owner advances
//    (wrap N-1->0) when slot_cnt wraps. Advances every cycle independent of traffic. sel=owner
//    always; non-owner requests never reach reqs even if owner idle (non-work-conserving).
//    Lock and ptr unused.
//  - cur_dom = sel every cycle.
//  - Reset (sync): ptr<=N-1 (domain 0 highest RR priority first), lock_vld<=0, lock_dom<=0,
//    owner<=0, slot_cnt<=0. During/after reset with in_val=0: reqs=0, in_rdy=0, cur_dom=0.
//    Reset mid-lock or mid-slot discards state; next cycle behaves as post-reset.
//  - grants with bits outside reqs_sel are ignored (no transfer). N not power of 2: all
//    modulo counters wrap explicitly at N-1.
// STRUCTURE
//  - Shared package/header plab4-net-RouterDomainArb-Defs: mode constants (FIXED/RR/TDM),
//    clog2-min-1 macro for c_dom_nbits.
//  - Sub-module: plab4_net_RouterInputCtrl_NOTP, one per domain via generate (route compute).
//  - Local: rr priority picker (rotate, find-first, rotate back), lock regs, TDM counters.
// TESTING
//  - Reset: assert reset 2 cycles with in_val=all 1 -> cycle after release FIXED/RR pick dom0;
//    TDM cur_dom=0, slot_cnt=0.
//  - FIXED, N=2, both valid, grants match each cycle -> dom0 in_rdy every cycle, dom1 starved.
//  - RR, N=3, all valid continuously, grants always match -> in_rdy one-hot sequence 0,1,2,0,1,2.
//  - Lock, RR: dom1 requests, grants=0 for 3 cycles while dom0 becomes valid -> sel stays 1;
//    grant on cycle 4 -> in_rdy[1]=1, next cycle dom0/dom2 eligible; drop in_val[1] mid-lock
//    -> lock clears next cycle.
//  - TDM, N=2, slot=4, only dom1 valid from cycle 0 -> reqs=0 cycles 0-3, dom1 transfers
//    cycles 4-7, reqs=0 cycles 8-11 (dom1 timing independent of dom0 load).
//  - TDM wrap, N=3, slot=1 -> cur_dom 0,1,2,0; reset asserted at owner=2 -> owner 0 next cycle.

Source files
------------

// File: rtl/plab4_net_router_input_ctrl_domain_arb_pkg.sv
// Shared definitions for the multi-domain router input controller:
// arbitration modes, request encodings and width helpers.
package plab4_net_router_input_ctrl_domain_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MODE_TDM   = 2;

    typedef logic [2:0] reqs_t;

    // Output-port requests: bit 2 heads toward increasing router ids, bit 1 toward decreasing.
    localparam reqs_t REQS_NONE = 3'b000;
    localparam reqs_t REQS_INC  = 3'b100;
    localparam reqs_t REQS_DEC  = 3'b010;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plab4_net_router_input_ctrl_domain_arb_notp.sv
// Ring route compute for one domain's queue head: terminal pattern when the packet
// is addressed here, otherwise the shorter ring direction (ties go toward increasing ids).
module plab4_net_router_input_ctrl_domain_arb_notp
    import plab4_net_router_input_ctrl_domain_arb_pkg::*;
#(
    parameter int          p_router_id    = 0,
    parameter int          p_num_routers  = 8,
    parameter logic [2:0]  p_default_reqs = 3'b001,
    localparam int         c_dest_nbits   = clog2_min1(p_num_routers)
) (
    input  logic [c_dest_nbits-1:0] dest_i,
    input  logic                    val_i,
    output logic [2:0]              reqs_o
);

    localparam logic [31:0] c_id   = 32'(p_router_id);
    localparam logic [31:0] c_n    = 32'(p_num_routers);
    localparam logic [31:0] c_half = 32'(p_num_routers / 2);

    logic [31:0] dest_ext_s;
    logic [31:0] fwd_dist_s;
    reqs_t       route_s;

    // Forward ring distance, then direction choice gated by head valid.
    always_comb begin
        dest_ext_s = 32'(dest_i);
        if (dest_ext_s >= c_id) begin
            fwd_dist_s = dest_ext_s - c_id;
        end else begin
            fwd_dist_s = dest_ext_s + c_n - c_id;
        end

        if (fwd_dist_s == 32'd0) begin
            route_s = p_default_reqs;
        end else if (fwd_dist_s <= c_half) begin
            route_s = REQS_INC;
        end else begin
            route_s = REQS_DEC;
        end

        if (val_i) begin
            reqs_o = route_s;
        end else begin
            reqs_o = REQS_NONE;
        end
    end

endmodule

// File: rtl/plab4_net_router_input_ctrl_domain_arb.sv
// Router input-port controller shared by several security domains: per-domain route
// compute plus a domain arbiter (fixed priority, round-robin with lock, or TDM slots).
module plab4_net_router_input_ctrl_domain_arb
    import plab4_net_router_input_ctrl_domain_arb_pkg::*;
#(
    parameter int          p_router_id    = 0,
    parameter int          p_num_routers  = 8,
    parameter int          p_num_domains  = 2,
    parameter logic [2:0]  p_default_reqs = 3'b001,
    parameter int          p_mode         = MODE_FIXED,
    parameter int          p_slot_cycles  = 4,
    localparam int         c_dest_nbits   = clog2_min1(p_num_routers),
    localparam int         c_dom_nbits    = clog2_min1(p_num_domains)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [p_num_domains*c_dest_nbits-1:0] dest_i,
    input  logic [p_num_domains-1:0]              in_val_i,
    output logic [p_num_domains-1:0]              in_rdy_o,
    output logic [2:0]                            reqs_o,
    input  logic [2:0]                            grants_i,
    output logic [c_dom_nbits-1:0]                cur_dom_o
);

    localparam int                     c_slot_nbits = clog2_min1(p_slot_cycles);
    localparam logic [c_dom_nbits-1:0] c_last_dom   = c_dom_nbits'(p_num_domains - 1);
    localparam logic [c_dom_nbits-1:0] c_dom_zero   = c_dom_nbits'(0);
    localparam logic [c_dom_nbits-1:0] c_dom_one    = c_dom_nbits'(1);
    localparam logic [c_slot_nbits-1:0] c_last_slot = c_slot_nbits'(p_slot_cycles - 1);
    localparam logic [c_slot_nbits-1:0] c_slot_zero = c_slot_nbits'(0);
    localparam logic [c_slot_nbits-1:0] c_slot_one  = c_slot_nbits'(1);

    reqs_t                    reqs_dom_s [p_num_domains];

    logic [c_dom_nbits-1:0]   ptr_q,      ptr_d;
    logic                     lock_vld_q, lock_vld_d;
    logic [c_dom_nbits-1:0]   lock_dom_q, lock_dom_d;
    logic [c_dom_nbits-1:0]   owner_q,    owner_d;
    logic [c_slot_nbits-1:0]  slot_cnt_q, slot_cnt_d;

    logic [c_dom_nbits-1:0]   fix_sel_s;
    logic                     fix_found_s;
    logic                     fix_hit_s;
    logic [c_dom_nbits-1:0]   rr_sel_s;
    logic [c_dom_nbits-1:0]   rr_idx_s;
    logic                     rr_found_s;
    logic                     rr_hit_s;

    logic                     lock_eff_s;
    logic [c_dom_nbits-1:0]   sel_s;
    reqs_t                    reqs_sel_s;
    logic                     xfer_s;
    logic [p_num_domains-1:0] in_rdy_s;

    for (genvar d = 0; d < p_num_domains; d++) begin : g_route
        plab4_net_router_input_ctrl_domain_arb_notp #(
            .p_router_id    (p_router_id),
            .p_num_routers  (p_num_routers),
            .p_default_reqs (p_default_reqs)
        ) u_route (
            .dest_i (dest_i[d*c_dest_nbits +: c_dest_nbits]),
            .val_i  (in_val_i[d]),
            .reqs_o (reqs_dom_s[d])
        );
    end

    // Fixed priority: lowest-numbered domain with a non-empty request wins; domain 0 if none.
    always_comb begin
        fix_sel_s   = c_dom_zero;
        fix_found_s = 1'b0;
        fix_hit_s   = 1'b0;
        for (int d = 0; d < p_num_domains; d++) begin
            fix_hit_s   = !fix_found_s && (reqs_dom_s[d] != REQS_NONE);
            fix_sel_s   = fix_hit_s ? c_dom_nbits'(d) : fix_sel_s;
            fix_found_s = fix_found_s | fix_hit_s;
        end
    end

    // Round-robin: walk domains starting just after the last winner, wrapping at N-1.
    always_comb begin
        rr_sel_s   = c_dom_zero;
        rr_found_s = 1'b0;
        rr_hit_s   = 1'b0;
        rr_idx_s   = (ptr_q == c_last_dom) ? c_dom_zero : ptr_q + c_dom_one;
        for (int i = 0; i < p_num_domains; i++) begin
            rr_hit_s   = !rr_found_s && (reqs_dom_s[rr_idx_s] != REQS_NONE);
            rr_sel_s   = rr_hit_s ? rr_idx_s : rr_sel_s;
            rr_found_s = rr_found_s | rr_hit_s;
            rr_idx_s   = (rr_idx_s == c_last_dom) ? c_dom_zero : rr_idx_s + c_dom_one;
        end
    end

    // Domain selection and grant steering; a lock whose holder went idle no longer pins sel.
    always_comb begin
        lock_eff_s = lock_vld_q & in_val_i[lock_dom_q];
        case (p_mode)
            MODE_TDM: sel_s = owner_q;
            MODE_RR:  sel_s = lock_eff_s ? lock_dom_q : rr_sel_s;
            default:  sel_s = lock_eff_s ? lock_dom_q : fix_sel_s;
        endcase
        reqs_sel_s      = reqs_dom_s[sel_s];
        xfer_s          = |(grants_i & reqs_sel_s);
        in_rdy_s        = '0;
        in_rdy_s[sel_s] = xfer_s;
    end

    assign reqs_o    = reqs_sel_s;
    assign in_rdy_o  = in_rdy_s;
    assign cur_dom_o = sel_s;

    // Next state for RR pointer, request lock and TDM slot counters.
    always_comb begin
        if ((p_mode == MODE_RR) && xfer_s) begin
            ptr_d = sel_s;
        end else begin
            ptr_d = ptr_q;
        end

        // A pending request that was not granted holds the port for its domain.
        if ((p_mode != MODE_TDM) && (reqs_sel_s != REQS_NONE) && !xfer_s) begin
            lock_vld_d = 1'b1;
            lock_dom_d = sel_s;
        end else begin
            lock_vld_d = 1'b0;
            lock_dom_d = lock_dom_q;
        end

        if (p_mode == MODE_TDM) begin
            if (slot_cnt_q == c_last_slot) begin
                slot_cnt_d = c_slot_zero;
                owner_d    = (owner_q == c_last_dom) ? c_dom_zero : owner_q + c_dom_one;
            end else begin
                slot_cnt_d = slot_cnt_q + c_slot_one;
                owner_d    = owner_q;
            end
        end else begin
            slot_cnt_d = slot_cnt_q;
            owner_d    = owner_q;
        end
    end

    // State registers with synchronous reset; domain 0 gets first RR turn after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= c_last_dom;
            lock_vld_q <= 1'b0;
            lock_dom_q <= c_dom_zero;
            owner_q    <= c_dom_zero;
            slot_cnt_q <= c_slot_zero;
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_dom_q <= lock_dom_d;
            owner_q    <= owner_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_domain_arb.sv
// Directed, table-driven bench: four arbiter configurations (FIXED N=2, RR N=3,
// TDM N=2 slot 4, TDM N=3 slot 1) share stimulus; each row checks one of them.
module tb_plab4_net_router_input_ctrl_domain_arb;

    localparam int T_FX = 0;
    localparam int T_RR = 1;
    localparam int T_T2 = 2;
    localparam int T_T3 = 3;

    // Per-domain dests {d2,d1,d0}: d0=2 -> 100, d1=0 (terminal) -> 001, d2=6 -> 010.
    localparam logic [8:0] D_STD = {3'd6, 3'd0, 3'd2};
    localparam logic [8:0] D_D5  = {3'd5, 3'd0, 3'd2};
    localparam logic [8:0] D_D4  = {3'd4, 3'd0, 3'd2};

    typedef struct {
        logic       rst;
        logic [2:0] val;
        logic [8:0] dest;
        logic [2:0] gnt;
        int         tgt;
        logic       chk;
        logic       adv;
        logic [2:0] e_rdy;
        logic [2:0] e_reqs;
        logic [1:0] e_dom;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic reset;

    logic [1:0] fx_val, t2_val;
    logic [5:0] fx_dest, t2_dest;
    logic [2:0] fx_gnt, t2_gnt;
    logic [1:0] fx_rdy, t2_rdy;
    logic [2:0] fx_reqs, t2_reqs;
    logic [0:0] fx_dom, t2_dom;

    logic [2:0] rr_val, t3_val;
    logic [8:0] rr_dest, t3_dest;
    logic [2:0] rr_gnt, t3_gnt;
    logic [2:0] rr_rdy, t3_rdy;
    logic [2:0] rr_reqs, t3_reqs;
    logic [1:0] rr_dom, t3_dom;

    always #5 clk = ~clk;

    plab4_net_router_input_ctrl_domain_arb #(
        .p_num_domains(2), .p_mode(0), .p_slot_cycles(4)
    ) u_fx (
        .clk(clk), .reset(reset), .dest_i(fx_dest), .in_val_i(fx_val), .in_rdy_o(fx_rdy),
        .reqs_o(fx_reqs), .grants_i(fx_gnt), .cur_dom_o(fx_dom)
    );

    plab4_net_router_input_ctrl_domain_arb #(
        .p_num_domains(3), .p_mode(1), .p_slot_cycles(4)
    ) u_rr (
        .clk(clk), .reset(reset), .dest_i(rr_dest), .in_val_i(rr_val), .in_rdy_o(rr_rdy),
        .reqs_o(rr_reqs), .grants_i(rr_gnt), .cur_dom_o(rr_dom)
    );

    plab4_net_router_input_ctrl_domain_arb #(
        .p_num_domains(2), .p_mode(2), .p_slot_cycles(4)
    ) u_t2 (
        .clk(clk), .reset(reset), .dest_i(t2_dest), .in_val_i(t2_val), .in_rdy_o(t2_rdy),
        .reqs_o(t2_reqs), .grants_i(t2_gnt), .cur_dom_o(t2_dom)
    );

    plab4_net_router_input_ctrl_domain_arb #(
        .p_num_domains(3), .p_mode(2), .p_slot_cycles(1)
    ) u_t3 (
        .clk(clk), .reset(reset), .dest_i(t3_dest), .in_val_i(t3_val), .in_rdy_o(t3_rdy),
        .reqs_o(t3_reqs), .grants_i(t3_gnt), .cur_dom_o(t3_dom)
    );

    task automatic stim(input logic rst, input logic [2:0] val, input logic [8:0] dest,
                        input logic [2:0] gnt);
        cur.rst  = rst;
        cur.val  = val;
        cur.dest = dest;
        cur.gnt  = gnt;
    endtask

    task automatic go();
        vec_t v;
        v        = cur;
        v.tgt    = T_FX;
        v.chk    = 1'b0;
        v.adv    = 1'b1;
        v.e_rdy  = 3'b000;
        v.e_reqs = 3'b000;
        v.e_dom  = 2'd0;
        vecs.push_back(v);
    endtask

    task automatic ex(input int tgt, input logic adv, input logic [2:0] rdy,
                      input logic [2:0] reqs, input logic [1:0] dom);
        vec_t v;
        v        = cur;
        v.tgt    = tgt;
        v.chk    = 1'b1;
        v.adv    = adv;
        v.e_rdy  = rdy;
        v.e_reqs = reqs;
        v.e_dom  = dom;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input int row, input int tgt,
                       input logic [2:0] act, input logic [2:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s row %0d dut %0d: got %b expected %b", nm, row, tgt, act, exp_v);
        end
    endtask

    initial begin
        logic [2:0] a_rdy, a_reqs, a_dom;

        // Reset with every domain valid, then first cycle after release.
        stim(1'b1, 3'b111, D_STD, 3'b000); go(); go();
        stim(1'b0, 3'b111, D_STD, 3'b000);
        ex(T_FX, 1'b0, 3'b000, 3'b100, 2'd0);
        ex(T_RR, 1'b0, 3'b000, 3'b100, 2'd0);
        ex(T_T2, 1'b0, 3'b000, 3'b100, 2'd0);
        ex(T_T3, 1'b1, 3'b000, 3'b100, 2'd0);

        // FIXED: dom0 wins every cycle while both valid; dom1 only when dom0 idle.
        stim(1'b0, 3'b011, D_STD, 3'b100);
        for (int i = 0; i < 3; i++) ex(T_FX, 1'b1, 3'b001, 3'b100, 2'd0);
        stim(1'b0, 3'b010, D_STD, 3'b001); ex(T_FX, 1'b1, 3'b010, 3'b001, 2'd1);
        stim(1'b0, 3'b000, D_STD, 3'b000); ex(T_FX, 1'b1, 3'b000, 3'b000, 2'd0);
        stim(1'b0, 3'b011, D_STD, 3'b010); ex(T_FX, 1'b1, 3'b000, 3'b100, 2'd0);
        stim(1'b0, 3'b010, D_STD, 3'b001); ex(T_FX, 1'b1, 3'b010, 3'b001, 2'd1);

        // RR rotation with all valid and matching grants: 0,1,2,0,1,2.
        stim(1'b1, 3'b111, D_STD, 3'b000); go(); go();
        for (int i = 0; i < 2; i++) begin
            stim(1'b0, 3'b111, D_STD, 3'b100); ex(T_RR, 1'b1, 3'b001, 3'b100, 2'd0);
            stim(1'b0, 3'b111, D_STD, 3'b001); ex(T_RR, 1'b1, 3'b010, 3'b001, 2'd1);
            stim(1'b0, 3'b111, D_STD, 3'b010); ex(T_RR, 1'b1, 3'b100, 3'b010, 2'd2);
        end

        // RR lock: dom1 held through three ungranted cycles despite dom0 arriving.
        stim(1'b0, 3'b010, D_STD, 3'b000); ex(T_RR, 1'b1, 3'b000, 3'b001, 2'd1);
        stim(1'b0, 3'b011, D_STD, 3'b000);
        ex(T_RR, 1'b1, 3'b000, 3'b001, 2'd1);
        ex(T_RR, 1'b1, 3'b000, 3'b001, 2'd1);
        stim(1'b0, 3'b011, D_STD, 3'b001); ex(T_RR, 1'b1, 3'b010, 3'b001, 2'd1);
        stim(1'b0, 3'b111, D_STD, 3'b000); ex(T_RR, 1'b1, 3'b000, 3'b010, 2'd2);
        stim(1'b0, 3'b011, D_STD, 3'b000); go();
        stim(1'b0, 3'b011, D_STD, 3'b100); ex(T_RR, 1'b1, 3'b001, 3'b100, 2'd0);

        // Route boundaries: distance 5 goes decreasing, distance 4 (half ring) increasing.
        stim(1'b0, 3'b100, D_D5, 3'b010); ex(T_RR, 1'b1, 3'b100, 3'b010, 2'd2);
        stim(1'b0, 3'b100, D_D4, 3'b100); ex(T_RR, 1'b1, 3'b100, 3'b100, 2'd2);

        // TDM N=2 slot 4: only dom1 valid; it moves only in its own slot.
        stim(1'b1, 3'b010, D_STD, 3'b001); go(); go();
        stim(1'b0, 3'b010, D_STD, 3'b001);
        for (int i = 0; i < 12; i++) begin
            if (i >= 4 && i <= 7) ex(T_T2, 1'b1, 3'b010, 3'b001, 2'd1);
            else                  ex(T_T2, 1'b1, 3'b000, 3'b000, 2'd0);
        end

        // TDM N=3 slot 1: owner wrap, idle owner blocks others, reset at owner 2.
        stim(1'b1, 3'b000, D_STD, 3'b000); go(); go();
        stim(1'b0, 3'b000, D_STD, 3'b000);
        ex(T_T3, 1'b1, 3'b000, 3'b000, 2'd0);
        ex(T_T3, 1'b1, 3'b000, 3'b000, 2'd1);
        ex(T_T3, 1'b1, 3'b000, 3'b000, 2'd2);
        stim(1'b0, 3'b110, D_STD, 3'b000); ex(T_T3, 1'b1, 3'b000, 3'b000, 2'd0);
        stim(1'b0, 3'b111, D_STD, 3'b001); ex(T_T3, 1'b1, 3'b010, 3'b001, 2'd1);
        stim(1'b1, 3'b000, D_STD, 3'b000); ex(T_T3, 1'b1, 3'b000, 3'b000, 2'd2);
        stim(1'b0, 3'b000, D_STD, 3'b000);
        ex(T_T3, 1'b1, 3'b000, 3'b000, 2'd0);
        ex(T_T3, 1'b1, 3'b000, 3'b000, 2'd1);

        reset = 1'b1;
        fx_val = '0; fx_dest = '0; fx_gnt = '0;
        t2_val = '0; t2_dest = '0; t2_gnt = '0;
        rr_val = '0; rr_dest = '0; rr_gnt = '0;
        t3_val = '0; t3_dest = '0; t3_gnt = '0;
        @(posedge clk);
        #1;

        foreach (vecs[r]) begin
            reset   = vecs[r].rst;
            fx_val  = vecs[r].val[1:0];  fx_dest = vecs[r].dest[5:0]; fx_gnt = vecs[r].gnt;
            t2_val  = vecs[r].val[1:0];  t2_dest = vecs[r].dest[5:0]; t2_gnt = vecs[r].gnt;
            rr_val  = vecs[r].val;       rr_dest = vecs[r].dest;      rr_gnt = vecs[r].gnt;
            t3_val  = vecs[r].val;       t3_dest = vecs[r].dest;      t3_gnt = vecs[r].gnt;
            #1;
            if (vecs[r].chk) begin
                case (vecs[r].tgt)
                    T_FX: begin a_rdy = {1'b0, fx_rdy}; a_reqs = fx_reqs; a_dom = {2'b00, fx_dom}; end
                    T_RR: begin a_rdy = rr_rdy;         a_reqs = rr_reqs; a_dom = {1'b0, rr_dom};  end
                    T_T2: begin a_rdy = {1'b0, t2_rdy}; a_reqs = t2_reqs; a_dom = {2'b00, t2_dom}; end
                    default: begin a_rdy = t3_rdy;      a_reqs = t3_reqs; a_dom = {1'b0, t3_dom};  end
                endcase
                cmp("in_rdy",  r, vecs[r].tgt, a_rdy,  vecs[r].e_rdy);
                cmp("reqs",    r, vecs[r].tgt, a_reqs, vecs[r].e_reqs);
                cmp("cur_dom", r, vecs[r].tgt, a_dom,  {1'b0, vecs[r].e_dom});
            end
            if (vecs[r].adv) begin
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
